pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_if.sv | 40 ++++
 rtl/pipeline_control.sv | 144 ++++++++++++++
 tb/tb_pipeline_control.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_if.sv
// Decode-to-control bundle: opcode handshake from the decoder plus the
// per-stage control bundles and statistics returned by pipeline_control.
interface pipeline_control_if #(
    parameter int OPCODE_W = 6,
    parameter int WB_W     = 2,
    parameter int MEM_W    = 2,
    parameter int CALC_W   = 4
);
    logic [OPCODE_W-1:0] opCode;
    logic                opValid;
    logic                stall;
    logic                flush;

    logic [CALC_W-1:0]   exCalculationControl;
    logic [MEM_W-1:0]    exMemAccessControl;
    logic [WB_W-1:0]     exWriteBackControl;
    logic [MEM_W-1:0]    memMemAccessControl;
    logic [WB_W-1:0]     memWriteBackControl;
    logic [WB_W-1:0]     wbWriteBackControl;
    logic                exValid;
    logic                memValid;
    logic                wbValid;
    logic                illegalOp;
    logic [15:0]         issuedCount;
    logic [15:0]         bubbleCount;

    modport master (
        output opCode, opValid, stall, flush,
        input  exCalculationControl, exMemAccessControl, exWriteBackControl,
               memMemAccessControl, memWriteBackControl, wbWriteBackControl,
               exValid, memValid, wbValid, illegalOp, issuedCount, bubbleCount
    );

    modport slave (
        input  opCode, opValid, stall, flush,
        output exCalculationControl, exMemAccessControl, exWriteBackControl,
               memMemAccessControl, memWriteBackControl, wbWriteBackControl,
               exValid, memValid, wbValid, illegalOp, issuedCount, bubbleCount
    );
endinterface

// File: rtl/pipeline_control.sv
// Decodes opcodes into EX/MEM/WB control bundles and carries them down the pipe
// with stall/flush bubbles. Define PIPELINE_CONTROL_STATS_EN for issue/bubble counters.
module pipeline_control #(
    parameter int OPCODE_W = 6,
    parameter int WB_W     = 2,
    parameter int MEM_W    = 2,
    parameter int CALC_W   = 4
) (
    input  logic             clk,
    input  logic             resetN,
    pipeline_control_if.slave bus
);

    logic [CALC_W-1:0] decCalc;
    logic [MEM_W-1:0]  decMem;
    logic [WB_W-1:0]   decWb;
    logic              decIllegal;

    logic [CALC_W-1:0] exCalc;
    logic [MEM_W-1:0]  exMem;
    logic [WB_W-1:0]   exWb;
    logic [MEM_W-1:0]  memMem;
    logic [WB_W-1:0]   memWb;
    logic [WB_W-1:0]   wbWb;
    logic              exValidQ;
    logic              memValidQ;
    logic              wbValidQ;
    logic              illegalQ;

    logic              accept;
    logic              stallBubble;

    assign accept      = bus.opValid & ~bus.stall & ~bus.flush;
    assign stallBubble = bus.stall | bus.flush;

    // Control bits sit in the low field positions; any wider bits stay zero.
    always_comb begin
        decCalc    = '0;
        decMem     = '0;
        decWb      = '0;
        decIllegal = 1'b0;
        case (bus.opCode)
            OPCODE_W'(0): ;
            OPCODE_W'(1): begin
                decWb[1]     = 1'b1;
                decCalc[2:0] = 3'b010;
            end
            OPCODE_W'(2): begin
                decWb[1:0]  = 2'b11;
                decMem[1]   = 1'b1;
                decCalc[3]  = 1'b1;
            end
            OPCODE_W'(3): begin
                decMem[0]  = 1'b1;
                decCalc[3] = 1'b1;
            end
            OPCODE_W'(4): begin
                decWb[1]   = 1'b1;
                decCalc[3] = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exCalc    <= '0;
            exMem     <= '0;
            exWb      <= '0;
            exValidQ  <= 1'b0;
            memMem    <= '0;
            memWb     <= '0;
            memValidQ <= 1'b0;
            wbWb      <= '0;
            wbValidQ  <= 1'b0;
            illegalQ  <= 1'b0;
        end else begin
            wbWb     <= memWb;
            wbValidQ <= memValidQ;

            if (bus.flush) begin
                memMem    <= '0;
                memWb     <= '0;
                memValidQ <= 1'b0;
            end else begin
                memMem    <= exMem;
                memWb     <= exWb;
                memValidQ <= exValidQ;
            end

            if (accept) begin
                exCalc   <= decCalc;
                exMem    <= decMem;
                exWb     <= decWb;
                exValidQ <= 1'b1;
                illegalQ <= decIllegal;
            end else begin
                exCalc   <= '0;
                exMem    <= '0;
                exWb     <= '0;
                exValidQ <= 1'b0;
                illegalQ <= 1'b0;
            end
        end
    end

    assign bus.exCalculationControl = exCalc;
    assign bus.exMemAccessControl   = exMem;
    assign bus.exWriteBackControl   = exWb;
    assign bus.memMemAccessControl  = memMem;
    assign bus.memWriteBackControl  = memWb;
    assign bus.wbWriteBackControl   = wbWb;
    assign bus.exValid              = exValidQ;
    assign bus.memValid             = memValidQ;
    assign bus.wbValid              = wbValidQ;
    assign bus.illegalOp            = illegalQ;

`ifdef PIPELINE_CONTROL_STATS_EN
    logic [15:0] issuedQ;
    logic [15:0] bubbleQ;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            issuedQ <= '0;
            bubbleQ <= '0;
        end else begin
            if (accept && issuedQ != 16'hFFFF)
                issuedQ <= issuedQ + 16'd1;
            if (stallBubble && bubbleQ != 16'hFFFF)
                bubbleQ <= bubbleQ + 16'd1;
        end
    end

    assign bus.issuedCount = issuedQ;
    assign bus.bubbleCount = bubbleQ;
`else
    logic unusedStats;
    assign unusedStats     = stallBubble;
    assign bus.issuedCount = 16'd0;
    assign bus.bubbleCount = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios with literal
// expectations plus randomized traffic compared against a stage-list model.
module tb_pipeline_control;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    pipeline_control_if #(.OPCODE_W(6), .WB_W(2), .MEM_W(2), .CALC_W(4)) bus ();

    pipeline_control #(.OPCODE_W(6), .WB_W(2), .MEM_W(2), .CALC_W(4)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] calc;
        logic [1:0] mem;
        logic [1:0] wb;
    } stage_t;

    stage_t mEx, mMem, mWb;
    logic   mIll;
    int     mIssued, mBubble;

    // What a real instruction of this opcode must carry through the pipe.
    function automatic stage_t lookup(input logic [5:0] op);
        stage_t r;
        r   = '0;
        r.v = 1'b1;
        case (op)
            6'd1: begin r.wb = 2'b10; r.calc = 4'b0010; end
            6'd2: begin r.wb = 2'b11; r.mem = 2'b10; r.calc = 4'b1000; end
            6'd3: begin r.mem = 2'b01; r.calc = 4'b1000; end
            6'd4: begin r.wb = 2'b10; r.calc = 4'b1000; end
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mEx <= '0; mMem <= '0; mWb <= '0; mIll <= 1'b0;
            mIssued <= 0; mBubble <= 0;
        end else begin
            mWb  <= mMem;
            mMem <= bus.flush ? stage_t'(0) : mEx;
            if (bus.opValid && !bus.stall && !bus.flush) begin
                mEx  <= lookup(bus.opCode);
                mIll <= (bus.opCode > 6'd4);
`ifdef PIPELINE_CONTROL_STATS_EN
                mIssued <= (mIssued < 65535) ? mIssued + 1 : 65535;
`endif
            end else begin
                mEx  <= '0;
                mIll <= 1'b0;
            end
`ifdef PIPELINE_CONTROL_STATS_EN
            if (bus.stall || bus.flush)
                mBubble <= (mBubble < 65535) ? mBubble + 1 : 65535;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("exValid",  32'(bus.exValid),              32'(mEx.v));
        checkOutput("exCalc",   32'(bus.exCalculationControl), 32'(mEx.calc));
        checkOutput("exMem",    32'(bus.exMemAccessControl),   32'(mEx.mem));
        checkOutput("exWb",     32'(bus.exWriteBackControl),   32'(mEx.wb));
        checkOutput("memValid", 32'(bus.memValid),             32'(mMem.v));
        checkOutput("memMem",   32'(bus.memMemAccessControl),  32'(mMem.mem));
        checkOutput("memWb",    32'(bus.memWriteBackControl),  32'(mMem.wb));
        checkOutput("wbValid",  32'(bus.wbValid),              32'(mWb.v));
        checkOutput("wbWb",     32'(bus.wbWriteBackControl),   32'(mWb.wb));
        checkOutput("illegal",  32'(bus.illegalOp),            32'(mIll));
        checkOutput("issued",   32'(bus.issuedCount),          32'(mIssued));
        checkOutput("bubble",   32'(bus.bubbleCount),          32'(mBubble));
    end

    // Inputs change 2 time units after a rising edge and are sampled on the next one.
    task automatic applyStimulus(input logic [5:0] op, input logic v, input logic s, input logic f);
        @(posedge clk);
        #2;
        bus.opCode  = op;
        bus.opValid = v;
        bus.stall   = s;
        bus.flush   = f;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        resetN      = 1'b0;
        bus.opCode  = '0;
        bus.opValid = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        resetN      = 1'b0;
        bus.opCode  = '0;
        bus.opValid = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        #1;
        checkOutput("rstExValid", 32'(bus.exValid), 32'd0);
        checkOutput("rstWbValid", 32'(bus.wbValid), 32'd0);
        checkOutput("rstIssued",  32'(bus.issuedCount), 32'd0);
        doReset();

        // Back-to-back ALU, LOAD, STORE, ADDI.
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("seqCalc1", 32'(bus.exCalculationControl), 32'h2);
        applyStimulus(6'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("seqCalc2", 32'(bus.exCalculationControl), 32'h8);
        applyStimulus(6'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("seqCalc3", 32'(bus.exCalculationControl), 32'h8);
        checkOutput("seqWb1",   32'(bus.wbWriteBackControl),   32'h2);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("seqCalc4", 32'(bus.exCalculationControl), 32'h8);
        checkOutput("seqWb2",   32'(bus.wbWriteBackControl),   32'h3);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("seqWb3",   32'(bus.wbWriteBackControl),   32'h0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("seqWb4",   32'(bus.wbWriteBackControl),   32'h2);
        checkOutput("seqWbV4",  32'(bus.wbValid),              32'h1);
        drain();

        // Illegal opcode enters EX as a valid all-zero op with a one-cycle flag.
        applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("illPulse", 32'(bus.illegalOp), 32'h1);
        checkOutput("illValid", 32'(bus.exValid), 32'h1);
        checkOutput("illCalc",  32'(bus.exCalculationControl), 32'h0);
        checkOutput("illWb",    32'(bus.exWriteBackControl), 32'h0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("illDrop",  32'(bus.illegalOp), 32'h0);
        drain();

        // One stall cycle behind a LOAD.
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("stallExV",  32'(bus.exValid), 32'h0);
        checkOutput("stallMem",  32'(bus.memMemAccessControl), 32'h2);
        checkOutput("stallMemV", 32'(bus.memValid), 32'h1);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reissueV",  32'(bus.exValid), 32'h1);
        checkOutput("reissueC",  32'(bus.exCalculationControl), 32'h8);
        drain();

        // Flush while the LOAD is still in EX: nothing survives to WB.
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd3, 1'b1, 1'b1, 1'b1);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flushAExV",  32'(bus.exValid), 32'h0);
        checkOutput("flushAMemV", 32'(bus.memValid), 32'h0);
        checkOutput("flushAWbV",  32'(bus.wbValid), 32'h0);
        drain();

        // Flush once the LOAD has reached MEM: it still retires into WB.
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(6'd3, 1'b1, 1'b1, 1'b1);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flushBExV",  32'(bus.exValid), 32'h0);
        checkOutput("flushBMemV", 32'(bus.memValid), 32'h0);
        checkOutput("flushBWbV",  32'(bus.wbValid), 32'h1);
        checkOutput("flushBWb",   32'(bus.wbWriteBackControl), 32'h3);
        drain();

        // Asynchronous reset with three ops in flight.
        applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("preRstWbV", 32'(bus.wbValid), 32'h1);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("asyncExV",  32'(bus.exValid), 32'h0);
        checkOutput("asyncMemV", 32'(bus.memValid), 32'h0);
        checkOutput("asyncWbV",  32'(bus.wbValid), 32'h0);
        checkOutput("asyncMem",  32'(bus.memMemAccessControl), 32'h0);
        checkOutput("asyncWb",   32'(bus.wbWriteBackControl), 32'h0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
            applyStimulus(op, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 199) == 0) begin
                #1;
                resetN = 1'b0;
                #1;
                checkOutput("rndRstExV", 32'(bus.exValid), 32'h0);
                checkOutput("rndRstWbV", 32'(bus.wbValid), 32'h0);
                @(posedge clk);
                #1;
                resetN = 1'b1;
            end
        end

`ifdef PIPELINE_CONTROL_STATS_EN
        doReset();
        for (int i = 0; i < 70000; i++) applyStimulus(6'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(6'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("issuedSat",  32'(bus.issuedCount), 32'hFFFF);
        checkOutput("bubbleThree", 32'(bus.bubbleCount), 32'd3);
`else
        checkOutput("issuedZero", 32'(bus.issuedCount), 32'd0);
        checkOutput("bubbleZero", 32'(bus.bubbleCount), 32'd0);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
